rom_reader: RTL and testbench
=============================

# rom_reader

Sequencing reader for the team's 16x4 synchronous ROM (enable-gated, one-cycle registered read). It accepts a burst command (start address, length), drives the ROM's enable and address, absorbs the one-cycle read latency, and delivers the words on a valid/ready stream with a last marker. Backpressure is supported without losing or duplicating words. The block sits between the ROM and any consumer of ROM contents.

## Interface
- AW, 4, ROM address width; depth is 2^AW, wraps modulo 2^AW
- DW, 4, ROM data width
- clk  in  1  rising-edge clock, shared with the ROM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  burst request; sampled only in IDLE
- start_addr  in  AW  first address of the burst
- len_m1  in  AW  burst length minus one (1..2^AW words)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse in the cycle the last word is accepted
- rom_en  out  1  ROM read enable
- rom_addr  out  AW  ROM read address
- rom_data  in  DW  ROM registered output, valid in the cycle after rom_en
- out_data  out  DW  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks the final word of the burst; qualified by out_valid

## Operation
- FSM states:
  - IDLE: start=1 latches start_addr into the address counter, latches len_m1+1 into the issue and accept counters, then goes to RUN. start in any other state is ignored.
  - RUN: issues reads. Goes to DRAIN in the cycle after the last issue.
  - DRAIN: waits until the final word is accepted, then returns to IDLE.
- A 2-entry output FIFO holds returned words. inflight is 1 in the cycle after an issue and 0 otherwise.
- Issue condition, evaluated in RUN with issues remaining: fifo_count + inflight - pop < 2, where pop = out_valid & out_ready.
- On issue: rom_en=1 and rom_addr = current address, both combinational from registered state. The address counter increments mod 2^AW (15 -> 0), and the issue counter decrements.
- rom_data is pushed into the FIFO only in the cycle after an issue. At all other times rom_data is ignored, including when it is X.
- The FIFO may push and pop in the same cycle. Overflow cannot occur by construction; the bench asserts this.
- out_valid = fifo not empty. out_data = FIFO head.
- out_last = out_valid & (accept counter == 1). The accept counter decrements on each pop.
- done = pop & out_last. busy falls in the cycle after done.
- rom_en=0 and rom_addr holds its value whenever no issue occurs.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; FIFO empty; counters 0.
  - busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0.
- Start accepted at edge of cycle 0:
  - Cycle 1: busy=1, rom_en=1, rom_addr=start_addr.
  - Cycle 2: rom_data valid and pushed.
  - Cycle 3: out_valid=1.
- With out_ready held high: one word per cycle. A burst of N words has its last word accepted in cycle N+2, done=1 in that cycle, and busy=0 in cycle N+3.
- A new start is accepted in the first IDLE cycle, which is the cycle busy=0.
- Reset asserted mid-burst: all outputs return to reset values immediately. In-flight and buffered words are discarded, and no done pulse is produced.
- len_m1=2^AW-1 reads all addresses exactly once, wrapping back to start_addr-1.

## Test plan
- Read 4 words from addr 0 with out_ready=1 (ROM words 2,2,E,2) -> stream 2,2,E,2. out_last on the 4th word. done in cycle 6; first out_valid in cycle 3.
- Wrap: start_addr=14, len_m1=3 (ROM words C,0,2,2) -> rom_addr sequence 14,15,0,1; stream C,0,2,2; exactly 4 rom_en pulses.
- Backpressure: a 16-word burst from 5 with out_ready toggling in a pseudo-random pattern -> all 16 words in order with no duplication. FIFO count never exceeds 2. rom_en=0 while the FIFO is full with no pop.
- Single word (len_m1=0) at addr 2 -> exactly one beat E with out_last=1 and done=1 in the same cycle. start pulsed during busy is ignored.
- Reset asserted during cycle 2 of a burst -> all outputs 0 in that cycle. After release with start at addr 8, len_m1=1, the stream is exactly the ROM words at addresses 8 and 9, with no stale beat.

Source files
------------

// File: rtl/rom_reader_if.sv
// Bundles the burst command, ROM read port and output stream of rom_reader.
// master: the reader's view. slave: the view of the environment around it.
interface rom_reader_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) ();
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] len_m1;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    input  start, start_addr, len_m1, rom_data, out_ready,
    output busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, start_addr, len_m1, rom_data, out_ready,
    input  busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_reader.sv
// Burst reader for a synchronous ROM with one-cycle registered read.
// Reads are only issued when the 2-entry FIFO is guaranteed room for the returning word,
// so backpressure never drops or duplicates data.
module rom_reader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input logic        clk,
  input logic        rst_n,
  rom_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] AddrOne = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [AW:0]   accept_cnt_q, accept_cnt_d;
  logic [AW-1:0] rom_addr_q;
  logic          inflight_q;

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  logic       pop, push, issue;
  logic [2:0] occupancy;

  // Handshake and issue decision; occupancy counts words already owed a FIFO slot.
  always_comb begin
    pop       = (count_q != 2'd0) & bus.out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == StRun) && (issue_cnt_q != '0) && (occupancy < 3'd2);
  end

  // Outputs; rom_addr shows the live address only while issuing, otherwise the last one used.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (count_q != 2'd0);
    bus.out_data  = mem_q[rd_ptr_q];
    bus.out_last  = bus.out_valid & (accept_cnt_q == CntOne);
    bus.done      = pop & bus.out_last;
    bus.rom_en    = issue;
    bus.rom_addr  = issue ? addr_q : rom_addr_q;
  end

  // Next-state logic for the FSM and burst counters.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d       = bus.start_addr;
          issue_cnt_d  = {1'b0, bus.len_m1} + CntOne;
          accept_cnt_d = {1'b0, bus.len_m1} + CntOne;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + AddrOne;
          issue_cnt_d = issue_cnt_q - CntOne;
          if (issue_cnt_q == CntOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (bus.done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      accept_cnt_d = accept_cnt_q - CntOne;
    end
  end

  // FSM, counters and read-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      rom_addr_q   <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      inflight_q   <= issue;
      if (issue) begin
        rom_addr_q <= addr_q;
      end
    end
  end

  // Output FIFO; rom_data is captured only in the cycle after an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.rom_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: a ROM model, a per-cycle behavioural reference
// (expected word/address queues and occupancy arithmetic) and directed plus random bursts.
module tb_rom_reader;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  rom_reader_if #(.AW(4), .DW(4)) bus ();

  rom_reader #(.AW(4), .DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] rom [16];
  initial begin
    rom[0]  = 4'h2; rom[1]  = 4'h2; rom[2]  = 4'hE; rom[3]  = 4'h2;
    rom[4]  = 4'h5; rom[5]  = 4'h9; rom[6]  = 4'h1; rom[7]  = 4'h7;
    rom[8]  = 4'h3; rom[9]  = 4'hB; rom[10] = 4'h4; rom[11] = 4'h6;
    rom[12] = 4'h8; rom[13] = 4'hD; rom[14] = 4'hC; rom[15] = 4'h0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: garbage on the data bus whenever the previous cycle had no enable.
  always @(posedge clk) bus.rom_data <= bus.rom_en ? rom[bus.rom_addr] : 4'($urandom);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  logic [3:0] m_data [$];
  int         m_addr [$];
  bit         m_busy;
  int         issued, popped, prev_en;

  // Per-cycle comparison against the reference, sampled on the falling edge.
  initial begin
    bit pop;
    bit next_busy;
    int fifo_cnt;
    int n;
    m_busy = 0; issued = 0; popped = 0; prev_en = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_data", bus.out_data, 0);
        m_data.delete(); m_addr.delete();
        m_busy = 0; issued = 0; popped = 0; prev_en = 0;
      end else begin
        pop       = bus.out_valid && bus.out_ready;
        next_busy = m_busy;
        fifo_cnt  = issued - popped - prev_en;
        chk("busy", bus.busy, int'(m_busy));
        chk("fifo_le2", int'(fifo_cnt <= 2), 1);
        chk("valid", bus.out_valid, int'(fifo_cnt > 0));
        if (fifo_cnt == 2 && !pop) chk("en_while_full", bus.rom_en, 0);
        if (m_addr.size() == 0) begin
          chk("en_extra", bus.rom_en, 0);
        end else if (bus.rom_en) begin
          chk("rom_addr", bus.rom_addr, m_addr.pop_front());
        end
        if (pop) begin
          if (m_data.size() == 0) begin
            chk("pop_extra", int'(pop), 0);
          end else begin
            chk("data", bus.out_data, m_data[0]);
            chk("last", bus.out_last, int'(m_data.size() == 1));
            chk("done", bus.done, int'(m_data.size() == 1));
            if (m_data.size() == 1) next_busy = 0;
            void'(m_data.pop_front());
          end
        end else begin
          chk("done_nopop", bus.done, 0);
          if (bus.out_valid) chk("last_hold", bus.out_last, int'(m_data.size() == 1));
          else chk("last_novalid", bus.out_last, 0);
        end
        if (!m_busy && bus.start) begin
          next_busy = 1;
          n = int'(bus.len_m1) + 1;
          for (int i = 0; i < n; i++) begin
            m_addr.push_back((int'(bus.start_addr) + i) % 16);
            m_data.push_back(rom[(int'(bus.start_addr) + i) % 16]);
          end
        end
        issued  += int'(bus.rom_en);
        popped  += int'(pop);
        prev_en  = int'(bus.rom_en);
        m_busy   = next_busy;
      end
    end
  end

  logic [3:0] got [$];

  // One burst: start in cycle 0, record first-valid and done cycles relative to it.
  task automatic burst(input int a, input int l, input bit rnd, input bit pulse,
                       output int fv, output int dn, output int nen);
    int s;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = 4'(a);
    bus.len_m1     = 4'(l);
    bus.out_ready  = rnd ? 1'($urandom) : 1'b1;
    s   = cyc;
    fv  = -1;
    dn  = -1;
    nen = 0;
    got.delete();
    for (int k = 0; k < 300 && dn < 0; k++) begin
      @(negedge clk);
      if (bus.out_valid && fv < 0) fv = cyc - s;
      if (bus.rom_en) nen++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      if (bus.done) dn = cyc - s;
      @(posedge clk); #1;
      bus.start      = pulse && (k == 1);
      bus.start_addr = 4'($urandom);
      bus.len_m1     = 4'($urandom);
      bus.out_ready  = rnd ? 1'($urandom) : 1'b1;
    end
    chk("burst_timeout", int'(dn >= 0), 1);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    int fv, dn, nen;
    int a, l;
    logic [3:0] e1 [4];
    logic [3:0] e2 [4];
    e1[0] = 4'h2; e1[1] = 4'h2; e1[2] = 4'hE; e1[3] = 4'h2;
    e2[0] = 4'hC; e2[1] = 4'h0; e2[2] = 4'h2; e2[3] = 4'h2;
    tests = 0; fails = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.start_addr = '0; bus.len_m1 = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Four words from address 0, ready held high.
    burst(0, 3, 0, 0, fv, dn, nen);
    chk("t1_first_valid", fv, 3);
    chk("t1_done_cycle", dn, 6);
    chk("t1_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t1_word", got[i], e1[i]);

    // Address wrap 14,15,0,1.
    burst(14, 3, 0, 0, fv, dn, nen);
    chk("t2_en_pulses", nen, 4);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_word", got[i], e2[i]);

    // Full 16-word burst from 5 under random backpressure.
    burst(5, 15, 1, 0, fv, dn, nen);
    chk("t3_en_pulses", nen, 16);
    chk("t3_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t3_word", got[i], rom[(5 + i) % 16]);

    // Single word with a stray start pulse during busy.
    burst(2, 0, 0, 1, fv, dn, nen);
    chk("t4_count", got.size(), 1);
    if (got.size() > 0) chk("t4_word", got[0], 4'hE);
    chk("t4_done_cycle", dn, 3);

    // Reset in cycle 2 of a burst, then a clean two-word burst.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = 4'd5; bus.len_m1 = 4'd7; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_rom_en", bus.rom_en, 0);
    chk("t5_rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    burst(8, 1, 0, 0, fv, dn, nen);
    chk("t5_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_word0", got[0], 4'h3);
      chk("t5_word1", got[1], 4'hB);
    end

    // Random bursts checked by the reference model.
    for (int r = 0; r < 25; r++) begin
      a = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      burst(a, l, 1'($urandom), 1'($urandom), fv, dn, nen);
      chk("rnd_count", got.size(), l + 1);
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
